// File: rtl/jt12_host_writer_if.sv
// Request handshake and YM2612 CPU-port pins of jt12_host_writer.
// Handshake: a request transfers on every clk edge where req_valid && req_ready;
// the host holds req_part/req_reg/req_val stable while req_valid is high and
// req_ready is low, and req_ready never depends combinationally on req_valid.
interface jt12_host_writer_if;
    logic       req_valid;
    logic       req_ready;
    logic       req_part;
    logic [7:0] req_reg;
    logic [7:0] req_val;
    logic       cs_n;
    logic       wr_n;
    logic [1:0] addr;
    logic [7:0] dout;
    logic [7:0] din;

    // Writer side: accepts requests, drives the chip bus.
    modport master (
        input  req_valid, req_part, req_reg, req_val, din,
        output req_ready, cs_n, wr_n, addr, dout
    );

    // Host/chip side: issues requests, observes the bus, returns status.
    modport slave (
        output req_valid, req_part, req_reg, req_val, din,
        input  req_ready, cs_n, wr_n, addr, dout
    );
endinterface

// File: rtl/jt12_host_writer.sv
// Queues {part,reg,val} register writes and replays each one on the YM2612
// CPU port as an address write followed by a data write, polling the busy
// flag (din[7]) before each write. The last latched address is cached so a
// repeated register only needs its data phase.
module jt12_host_writer #(
    parameter int FIFO_AW    = 2,
    parameter int WR_PULSE   = 2,
    parameter int TIMEOUT    = 1023,
    parameter int ADDR_CACHE = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cen_i,
    input  logic               err_clr_i,
    jt12_host_writer_if.master bus,
    output logic               done_o,
    output logic               active_o,
    output logic               err_o,
    output logic [FIFO_AW:0]   level_o,
    output logic [2:0]         state_o
);
    localparam int DEPTH   = 1 << FIFO_AW;
    localparam int CNT_MAX = (TIMEOUT > WR_PULSE) ? TIMEOUT : WR_PULSE;
    localparam int CW      = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        POLL_A = 3'd1,
        WR_A   = 3'd2,
        REC_A  = 3'd3,
        POLL_D = 3'd4,
        WR_D   = 3'd5,
        REC_D  = 3'd6,
        ABORT  = 3'd7
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [1:0]       addr_q, addr_d;
    logic             err_q, err_d;
    logic             cache_v_q, cache_v_d;
    logic [8:0]       cache_q, cache_d;
    logic             part_q;
    logic [7:0]       reg_q, val_q;

    // FIFO entries are {part, reg, val}; pointers carry one wrap bit.
    logic [16:0]      mem_q [DEPTH];
    logic [FIFO_AW:0] wp_q, rp_q;
    logic [16:0]      head;
    logic             push, pop, empty, full, cache_hit, busy;
    logic             unused_din;

    assign empty      = (wp_q == rp_q);
    assign full       = (wp_q[FIFO_AW] != rp_q[FIFO_AW]) &&
                        (wp_q[FIFO_AW-1:0] == rp_q[FIFO_AW-1:0]);
    assign push       = bus.req_valid && !full;
    assign head       = mem_q[rp_q[FIFO_AW-1:0]];
    assign cache_hit  = (ADDR_CACHE != 0) && cache_v_q && (cache_q == head[16:8]);
    assign busy       = bus.din[7];
    assign unused_din = ^bus.din[6:0];

    // FIFO storage: written on push, no reset needed for the data itself.
    always_ff @(posedge clk) begin
        if (push) mem_q[wp_q[FIFO_AW-1:0]] <= {bus.req_part, bus.req_reg, bus.req_val};
    end

    // Next state: every transition waits for cen; the poll state's first
    // cycle lets the bus settle, later cycles sample busy and count.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        pop     = 1'b0;
        if (cen_i) begin
            case (state_q)
                IDLE: begin
                    if (!empty) begin
                        pop   = 1'b1;
                        cnt_d = '0;
                        if (cache_hit) begin
                            state_d = POLL_D;
                            addr_d  = {head[16], 1'b1};
                        end else begin
                            state_d = POLL_A;
                            addr_d  = {head[16], 1'b0};
                        end
                    end
                end
                POLL_A, POLL_D: begin
                    if (cnt_q == '0) begin
                        cnt_d = CW'(1);
                    end else if (!busy) begin
                        state_d = (state_q == POLL_A) ? WR_A : WR_D;
                        cnt_d   = '0;
                    end else if (cnt_q == CW'(TIMEOUT)) begin
                        state_d = ABORT;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                WR_A, WR_D: begin
                    if (cnt_q == CW'(WR_PULSE - 1)) state_d = (state_q == WR_A) ? REC_A : REC_D;
                    else                            cnt_d   = cnt_q + CW'(1);
                end
                REC_A: begin
                    state_d = POLL_D;
                    cnt_d   = '0;
                    addr_d  = {part_q, 1'b1};
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Sticky error and address cache; err_clr overrides a same-cycle abort.
    always_comb begin
        err_d     = err_q;
        cache_v_d = cache_v_q;
        cache_d   = cache_q;
        if (cen_i && state_q == REC_A) begin
            cache_v_d = 1'b1;
            cache_d   = {part_q, reg_q};
        end
        if (cen_i && state_q == ABORT) begin
            err_d     = 1'b1;
            cache_v_d = 1'b0;
        end
        if (err_clr_i) begin
            err_d     = 1'b0;
            cache_v_d = 1'b0;
        end
    end

    // State, counters, FIFO pointers and the popped request's work registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            addr_q    <= 2'b00;
            err_q     <= 1'b0;
            cache_v_q <= 1'b0;
            cache_q   <= '0;
            part_q    <= 1'b0;
            reg_q     <= '0;
            val_q     <= '0;
            wp_q      <= '0;
            rp_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            err_q     <= err_d;
            cache_v_q <= cache_v_d;
            cache_q   <= cache_d;
            if (push) wp_q <= wp_q + 1'b1;
            if (pop) begin
                rp_q   <= rp_q + 1'b1;
                part_q <= head[16];
                reg_q  <= head[15:8];
                val_q  <= head[7:0];
            end
        end
    end

    // Pin decode from the registered state; dout is only non-zero while writing.
    always_comb begin
        bus.cs_n = !(state_q == POLL_A || state_q == WR_A ||
                     state_q == POLL_D || state_q == WR_D);
        bus.wr_n = !(state_q == WR_A || state_q == WR_D);
        bus.addr = addr_q;
        case (state_q)
            WR_A:    bus.dout = reg_q;
            WR_D:    bus.dout = val_q;
            default: bus.dout = 8'h00;
        endcase
    end

    assign bus.req_ready = !full;
    assign done_o        = cen_i && (state_q == REC_D);
    assign active_o      = (state_q != IDLE) || !empty;
    assign err_o         = err_q;
    assign level_o       = wp_q - rp_q;
    assign state_o       = state_q;
endmodule

// File: tb/tb_jt12_host_writer.sv
// Bench for jt12_host_writer: randomized and directed requests against a
// queue-based model of the expected chip write sequence.
`timescale 1ns/1ps
module tb_jt12_host_writer;
    localparam int FIFO_AW    = 2;
    localparam int WR_PULSE   = 2;
    localparam int TIMEOUT    = 1023;
    localparam int ADDR_CACHE = 1;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             cen = 1'b1;
    logic             err_clr = 1'b0;
    logic             done, active, err;
    logic [FIFO_AW:0] level;
    logic [2:0]       state;

    jt12_host_writer_if bus();

    jt12_host_writer #(
        .FIFO_AW(FIFO_AW), .WR_PULSE(WR_PULSE), .TIMEOUT(TIMEOUT), .ADDR_CACHE(ADDR_CACHE)
    ) dut (
        .clk(clk), .rst(rst), .cen_i(cen), .err_clr_i(err_clr), .bus(bus),
        .done_o(done), .active_o(active), .err_o(err), .level_o(level), .state_o(state)
    );

    // Clock and reset
    always #5 clk = ~clk;

    int chk_cnt = 0;
    int err_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: expected chip writes as {addr, data}
    logic [9:0] exp_q[$];
    logic       m_cv = 1'b0;
    logic [8:0] m_ca = '0;

    task automatic model_push(input logic p, input logic [7:0] r, input logic [7:0] v);
        if (!(ADDR_CACHE != 0 && m_cv && m_ca == {p, r})) exp_q.push_back({p, 1'b0, r});
        exp_q.push_back({p, 1'b1, v});
        m_cv = 1'b1;
        m_ca = {p, r};
    endtask

    // Environment drivers for cen and chip status
    int cen_mode  = 0;
    int busy_mode = 0;
    logic pulse_chk = 1'b1;

    always @(posedge clk) begin
        #2;
        case (cen_mode)
            0:       cen = 1'b1;
            1:       cen = 1'b0;
            default: cen = ($urandom_range(0, 4) != 0);
        endcase
        case (busy_mode)
            0:       bus.din = 8'h00;
            1:       bus.din = 8'h80;
            default: bus.din = {($urandom_range(0, 2) == 0), 7'($urandom_range(0, 127))};
        endcase
    end

    // Bus monitor / scoreboard
    logic       prev_wr_n = 1'b1;
    logic       last_busy = 1'b0;
    logic [9:0] cur_wr = '0;
    logic [9:0] exp_wr;
    int low_cnt = 0, wr_cnt = 0, addr_wr_cnt = 0, data_wr_cnt = 0, done_cnt = 0;

    always @(negedge clk) begin
        if (rst) begin
            prev_wr_n = 1'b1;
            low_cnt   = 0;
        end else begin
            if (!bus.wr_n) begin
                if (prev_wr_n) check("wr_while_busy", 32'(last_busy), 0);
                check("cs_with_wr", 32'(bus.cs_n), 0);
                low_cnt++;
                cur_wr = {bus.addr, bus.dout};
            end else begin
                check("dout_idle", 32'(bus.dout), 0);
                if (!prev_wr_n) begin
                    wr_cnt++;
                    if (cur_wr[8]) data_wr_cnt++;
                    else           addr_wr_cnt++;
                    if (exp_q.size() == 0) begin
                        check("wr_unexpected", 32'(cur_wr), 32'h400);
                    end else begin
                        exp_wr = exp_q.pop_front();
                        check("wr_content", 32'(cur_wr), 32'(exp_wr));
                    end
                    if (pulse_chk) check("wr_pulse", 32'(low_cnt), WR_PULSE);
                    low_cnt = 0;
                end
            end
            if (done) begin
                done_cnt++;
                check("done_vs_data", 32'(done_cnt), 32'(data_wr_cnt));
            end
            prev_wr_n = bus.wr_n;
            last_busy = bus.din[7];
        end
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_req(input logic p, input logic [7:0] r, input logic [7:0] v, output int stalls);
        bus.req_valid = 1'b1;
        bus.req_part  = p;
        bus.req_reg   = r;
        bus.req_val   = v;
        stalls = 0;
        while (!bus.req_ready && stalls < 2000) begin
            tick();
            stalls++;
        end
        if (bus.req_ready) begin
            tick();
            model_push(p, r, v);
        end else begin
            check("push_timeout", 0, 1);
        end
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (active && n < budget) begin
            tick();
            n++;
        end
        check("idle_reached", 32'(active), 0);
        tick();
        check("queue_drained", 32'(exp_q.size()), 0);
    endtask

    task automatic pulse_err_clr();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        m_cv = 1'b0;
    endtask

    logic [7:0] regs[4] = '{8'h28, 8'hB4, 8'hA0, 8'h30};

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s, hit, dc, wc, ac, poll, viol, found;
        bus.req_valid = 1'b0;
        bus.req_part  = 1'b0;
        bus.req_reg   = 8'h00;
        bus.req_val   = 8'h00;
        bus.din       = 8'h00;
        #1 rst = 1'b1;
        repeat (3) tick();
        check("rst_cs_n", 32'(bus.cs_n), 1);
        check("rst_wr_n", 32'(bus.wr_n), 1);
        check("rst_addr", 32'(bus.addr), 0);
        check("rst_dout", 32'(bus.dout), 0);
        check("rst_done", 32'(done), 0);
        check("rst_err", 32'(err), 0);
        check("rst_level", 32'(level), 0);
        check("rst_ready", 32'(bus.req_ready), 1);
        check("rst_active", 32'(active), 0);
        rst = 1'b0;
        repeat (2) tick();

        // 1: single write, minimum latency
        push_req(1'b0, 8'h28, 8'hF0, s);
        check("t1_stalls", 32'(s), 0);
        check("t1_level", 32'(level), 1);
        hit = 0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (done && hit == 0) hit = k;
        end
        check("t1_done_cycle", 32'(hit), 10);
        check("t1_done_count", 32'(done_cnt), 1);
        check("t1_drained", 32'(exp_q.size()), 0);

        // 2: fill FIFO with cen low, fifth waits for first pop
        dc = done_cnt;
        cen_mode = 1;
        repeat (2) tick();
        for (int i = 0; i < 4; i++) begin
            push_req(1'b0, 8'h30 + 8'(i), 8'(i * 17), s);
            check("t2_push_stall", 32'(s), 0);
        end
        check("t2_level_full", 32'(level), 4);
        check("t2_ready_low", 32'(bus.req_ready), 0);
        bus.req_valid = 1'b1;
        bus.req_part  = 1'b1;
        bus.req_reg   = 8'hA4;
        bus.req_val   = 8'h5A;
        cen_mode = 0;
        s = 0;
        while (!bus.req_ready && s < 50) begin
            tick();
            s++;
        end
        check("t2_stall_cycles", 32'(s), 1);
        tick();
        model_push(1'b1, 8'hA4, 8'h5A);
        bus.req_valid = 1'b0;
        check("t2_level_after", 32'(level), 4);
        wait_idle(400);
        check("t2_done_count", 32'(done_cnt - dc), 5);

        // 3: busy held for 20 cycles in the data poll
        push_req(1'b0, 8'h40, 8'h77, s);
        found = 0;
        for (int k = 0; k < 100 && found == 0; k++) begin
            tick();
            if (!bus.cs_n && bus.addr == 2'b01) found = 1;
        end
        check("t3_reach_poll_d", 32'(found), 1);
        busy_mode = 1;
        viol = 0;
        repeat (20) begin
            tick();
            if (!bus.wr_n) viol++;
        end
        check("t3_no_write_busy", 32'(viol), 0);
        check("t3_still_polling", 32'(bus.cs_n), 0);
        busy_mode = 0;
        tick();
        check("t3_write_after_clear", 32'(bus.wr_n), 0);
        wait_idle(100);

        // 4: busy stuck -> abort after TIMEOUT samples, queue keeps going
        dc = done_cnt;
        wc = wr_cnt;
        busy_mode = 1;
        push_req(1'b0, 8'h22, 8'h08, s);
        poll = 0;
        for (int k = 0; k < 3000 && active; k++) begin
            tick();
            if (!bus.cs_n) poll++;
        end
        check("t4_poll_cycles", 32'(poll), TIMEOUT + 1);
        check("t4_err_set", 32'(err), 1);
        check("t4_no_done", 32'(done_cnt - dc), 0);
        check("t4_no_write", 32'(wr_cnt - wc), 0);
        exp_q.delete();
        m_cv = 1'b0;
        busy_mode = 0;
        push_req(1'b0, 8'h28, 8'h55, s);
        wait_idle(100);
        check("t4_next_done", 32'(done_cnt - dc), 1);
        check("t4_err_sticky", 32'(err), 1);
        pulse_err_clr();
        check("t4_err_cleared", 32'(err), 0);

        // 5: address cache
        ac = addr_wr_cnt;
        push_req(1'b1, 8'hB4, 8'h11, s);
        push_req(1'b1, 8'hB4, 8'h22, s);
        wait_idle(200);
        check("t5_cache_addr_writes", 32'(addr_wr_cnt - ac), 1);
        pulse_err_clr();
        ac = addr_wr_cnt;
        push_req(1'b1, 8'hB4, 8'h33, s);
        wait_idle(200);
        check("t5_clr_addr_writes", 32'(addr_wr_cnt - ac), 1);

        // Randomized traffic with random cen and busy
        cen_mode  = 2;
        busy_mode = 2;
        pulse_chk = 1'b0;
        dc = done_cnt;
        for (int i = 0; i < 40; i++) begin
            push_req(1'($urandom_range(0, 1)), regs[$urandom_range(0, 3)], 8'($urandom), s);
            repeat ($urandom_range(0, 3)) tick();
        end
        wait_idle(20000);
        check("rand_done_count", 32'(done_cnt - dc), 40);
        cen_mode  = 0;
        busy_mode = 0;
        pulse_chk = 1'b1;
        repeat (2) tick();

        // 6: reset during the data write
        push_req(1'b0, 8'h50, 8'h01, s);
        push_req(1'b0, 8'h51, 8'h02, s);
        found = 0;
        for (int k = 0; k < 100 && found == 0; k++) begin
            if (!bus.wr_n && bus.addr[0]) found = 1;
            else tick();
        end
        check("t6_reach_wr_d", 32'(found), 1);
        check("t6_level_before", 32'(level), 1);
        dc = done_cnt;
        #1 rst = 1'b1;
        #1;
        check("t6_cs_n", 32'(bus.cs_n), 1);
        check("t6_wr_n", 32'(bus.wr_n), 1);
        check("t6_level", 32'(level), 0);
        check("t6_done", 32'(done), 0);
        repeat (2) tick();
        rst = 1'b0;
        exp_q.delete();
        m_cv = 1'b0;
        repeat (30) tick();
        check("t6_no_done", 32'(done_cnt - dc), 0);
        check("t6_inactive", 32'(active), 0);
        check("final_drained", 32'(exp_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end
endmodule
